// File: rtl/noc_link_rebuffer_if.sv
// Bundle of one rebuffer's link-facing signals: the upstream receive side,
// the downstream send side, and the status outputs.
interface noc_link_rebuffer_if #(
   parameter int FLIT_WIDTH   = 32,
   parameter int DEST_WIDTH   = 6,
   parameter int BUFFER_DEPTH = 4
);
   localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);

   // Credit-flow link, no ready/stall signal:
   // - send_* marks one flit per cycle. The sender may assert it only while it
   //   holds a credit.
   // - credit_* is a one-cycle pulse that returns exactly one buffer slot.
   logic [FLIT_WIDTH-1:0] data_in;
   logic [DEST_WIDTH-1:0] dest_in;
   logic                  is_tail_in;
   logic                  send_in;
   logic                  credit_out;
   logic [FLIT_WIDTH-1:0] data_out;
   logic [DEST_WIDTH-1:0] dest_out;
   logic                  is_tail_out;
   logic                  send_out;
   logic                  credit_in;
   logic [OCC_W-1:0]      occupancy;
   logic                  overflow_err;
   logic                  credit_err;

   modport slave (
      input  data_in, dest_in, is_tail_in, send_in, credit_in,
      output credit_out, data_out, dest_out, is_tail_out, send_out,
      output occupancy, overflow_err, credit_err
   );

   modport master (
      output data_in, dest_in, is_tail_in, send_in, credit_in,
      input  credit_out, data_out, dest_out, is_tail_out, send_out,
      input  occupancy, overflow_err, credit_err
   );
endinterface

// File: rtl/noc_link_rebuffer.sv
// Credit-based link rebuffer: receives flits into a local FIFO, returns
// credits upstream, and forwards flits downstream against a mirrored credit count.
module noc_link_rebuffer #(
   parameter int FLIT_WIDTH         = 32,
   parameter int DEST_WIDTH         = 6,
   parameter int BUFFER_DEPTH       = 4,
   parameter int DOWNSTREAM_CREDITS = 4,
   parameter int NUM_PIPELINE       = 0
) (
   input logic                clk_noc,
   input logic                rst,
   noc_link_rebuffer_if.slave bus
);
   localparam int FW = FLIT_WIDTH + DEST_WIDTH + 1;
   localparam int OW = $clog2(BUFFER_DEPTH + 1);
   localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int CW = $clog2(DOWNSTREAM_CREDITS + 1);

   logic [FW-1:0] r_mem [BUFFER_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [OW-1:0] r_occ;
   logic [CW-1:0] r_cred;
   logic          r_credit_out;
   logic          r_overflow_err;
   logic          r_credit_err;
   logic          r_fwd_vld  [NUM_PIPELINE+1];
   logic [FW-1:0] r_fwd_flit [NUM_PIPELINE+1];

   logic          w_pop;
   logic          w_push;
   logic          w_credit_dly;
   logic [CW:0]   w_cred_sum;
   logic          w_cred_over;
   logic [FW-1:0] w_flit_in;

   function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
      return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_flit_in = {bus.data_in, bus.dest_in, bus.is_tail_in};

   // Pop decision uses only registered state; a returning credit never bypasses into it.
   assign w_pop  = (r_occ != '0) && (r_cred != '0);
   assign w_push = bus.send_in && ((r_occ < OW'(BUFFER_DEPTH)) || w_pop);

   // w_pop implies r_cred > 0, so the subtraction cannot underflow.
   assign w_cred_sum  = {1'b0, r_cred} - {{CW{1'b0}}, w_pop} + {{CW{1'b0}}, w_credit_dly};
   assign w_cred_over = (w_cred_sum > (CW+1)'(DOWNSTREAM_CREDITS));

   generate
      if (NUM_PIPELINE == 0) begin : g_credit_direct
         assign w_credit_dly = bus.credit_in;
      end else begin : g_credit_pipe
         logic [NUM_PIPELINE-1:0] r_cpipe;
         always_ff @(posedge clk_noc) begin
            if (rst) begin
               r_cpipe <= '0;
            end else begin
               r_cpipe[0] <= bus.credit_in;
               for (int i = 1; i < NUM_PIPELINE; i++) begin
                  r_cpipe[i] <= r_cpipe[i-1];
               end
            end
         end
         assign w_credit_dly = r_cpipe[NUM_PIPELINE-1];
      end
   endgenerate

   always_ff @(posedge clk_noc) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_flit_in;
      end
   end

   always_ff @(posedge clk_noc) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_occ          <= '0;
         r_cred         <= CW'(DOWNSTREAM_CREDITS);
         r_credit_out   <= 1'b0;
         r_overflow_err <= 1'b0;
         r_credit_err   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= f_ptr_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_ptr_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
         if (bus.send_in && !w_push) r_overflow_err <= 1'b1;
         r_credit_out <= w_pop;
         // Over-return saturates at the downstream buffer size and is flagged.
         if (w_cred_over) begin
            r_cred       <= CW'(DOWNSTREAM_CREDITS);
            r_credit_err <= 1'b1;
         end else begin
            r_cred <= w_cred_sum[CW-1:0];
         end
      end
   end

   // Stage 0 captures the popped flit; later stages shift unconditionally.
   always_ff @(posedge clk_noc) begin
      if (rst) begin
         for (int i = 0; i <= NUM_PIPELINE; i++) begin
            r_fwd_vld[i]  <= 1'b0;
            r_fwd_flit[i] <= '0;
         end
      end else begin
         r_fwd_vld[0] <= w_pop;
         if (w_pop) r_fwd_flit[0] <= r_mem[r_rd_ptr];
         for (int i = 1; i <= NUM_PIPELINE; i++) begin
            r_fwd_vld[i]  <= r_fwd_vld[i-1];
            r_fwd_flit[i] <= r_fwd_flit[i-1];
         end
      end
   end

   assign bus.send_out                                   = r_fwd_vld[NUM_PIPELINE];
   assign {bus.data_out, bus.dest_out, bus.is_tail_out} = r_fwd_flit[NUM_PIPELINE];
   assign bus.credit_out                                 = r_credit_out;
   assign bus.occupancy                                  = r_occ;
   assign bus.overflow_err                               = r_overflow_err;
   assign bus.credit_err                                 = r_credit_err;
endmodule

// File: tb/tb_noc_link_rebuffer.sv
// Directed bench for noc_link_rebuffer: instance A without forward pipeline,
// instance B with two stages for the latency check.
module tb_noc_link_rebuffer;
   localparam int FLIT_WIDTH         = 32;
   localparam int DEST_WIDTH         = 6;
   localparam int BUFFER_DEPTH       = 4;
   localparam int DOWNSTREAM_CREDITS = 4;
   localparam int FW                 = FLIT_WIDTH + DEST_WIDTH + 1;

   logic clk_noc = 1'b0;
   logic rst     = 1'b1;
   always #5 clk_noc = ~clk_noc;

   noc_link_rebuffer_if #(.FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH),
                          .BUFFER_DEPTH(BUFFER_DEPTH)) a_if ();
   noc_link_rebuffer_if #(.FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH),
                          .BUFFER_DEPTH(BUFFER_DEPTH)) b_if ();

   noc_link_rebuffer #(.FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH),
                       .BUFFER_DEPTH(BUFFER_DEPTH), .DOWNSTREAM_CREDITS(DOWNSTREAM_CREDITS),
                       .NUM_PIPELINE(0)) dut_a (
      .clk_noc (clk_noc),
      .rst     (rst),
      .bus     (a_if.slave)
   );

   noc_link_rebuffer #(.FLIT_WIDTH(FLIT_WIDTH), .DEST_WIDTH(DEST_WIDTH),
                       .BUFFER_DEPTH(BUFFER_DEPTH), .DOWNSTREAM_CREDITS(DOWNSTREAM_CREDITS),
                       .NUM_PIPELINE(2)) dut_b (
      .clk_noc (clk_noc),
      .rst     (rst),
      .bus     (b_if.slave)
   );

   int            n_cmp  = 0;
   int            n_err  = 0;
   int            sent_a = 0;
   int            s0;
   int            n_sent;
   logic [3:0]    ret_sh;
   logic [FW-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_noc);
      #1;
   endtask

   task automatic push_a(input logic [31:0] d, input logic [5:0] dst, input logic t, input bit track);
      a_if.send_in    = 1'b1;
      a_if.data_in    = d;
      a_if.dest_in    = dst;
      a_if.is_tail_in = t;
      if (track) exp_q.push_back({d, dst, t});
      tick(1);
      a_if.send_in = 1'b0;
   endtask

   task automatic credit_a(input int n);
      repeat (n) begin
         a_if.credit_in = 1'b1;
         tick(1);
      end
      a_if.credit_in = 1'b0;
   endtask

   // Scoreboard: every flit leaving A must be the oldest expected one.
   always @(negedge clk_noc) begin
      if (a_if.send_out) begin
         sent_a++;
         if (exp_q.size() == 0)
            check_eq("sb_unexpected_send", 64'(a_if.send_out), 64'(0));
         else
            check_eq("sb_flit", 64'({a_if.data_out, a_if.dest_out, a_if.is_tail_out}),
                     64'(exp_q.pop_front()));
      end
   end

   initial begin
      a_if.send_in = 1'b0; a_if.data_in = '0; a_if.dest_in = '0; a_if.is_tail_in = 1'b0;
      a_if.credit_in = 1'b0;
      b_if.send_in = 1'b0; b_if.data_in = '0; b_if.dest_in = '0; b_if.is_tail_in = 1'b0;
      b_if.credit_in = 1'b0;

      // Reset held two cycles while upstream keeps sending.
      rst = 1'b1;
      a_if.send_in = 1'b1; a_if.data_in = 32'h0BAD_0BAD;
      b_if.send_in = 1'b1; b_if.data_in = 32'h0BAD_0BAD;
      tick(2);
      check_eq("rst_send_out",   64'(a_if.send_out), 64'(0));
      check_eq("rst_credit_out", 64'(a_if.credit_out), 64'(0));
      check_eq("rst_occupancy",  64'(a_if.occupancy), 64'(0));
      check_eq("rst_ovf_err",    64'(a_if.overflow_err), 64'(0));
      check_eq("rst_cred_err",   64'(a_if.credit_err), 64'(0));
      check_eq("rst_data_out",   64'(a_if.data_out), 64'(0));
      rst = 1'b0;
      a_if.send_in = 1'b0;
      b_if.send_in = 1'b0;
      tick(1);
      check_eq("post_rst_occ", 64'(a_if.occupancy), 64'(0));

      // Single-flit latency on both instances.
      a_if.send_in = 1'b1; a_if.data_in = 32'hDEAD_BEEF; a_if.dest_in = 6'h15; a_if.is_tail_in = 1'b1;
      b_if.send_in = 1'b1; b_if.data_in = 32'hDEAD_BEEF; b_if.dest_in = 6'h15; b_if.is_tail_in = 1'b1;
      exp_q.push_back({32'hDEAD_BEEF, 6'h15, 1'b1});
      tick(1);
      a_if.send_in = 1'b0;
      b_if.send_in = 1'b0;
      check_eq("lat_a_occ_1",   64'(a_if.occupancy), 64'(1));
      check_eq("lat_a_early",   64'(a_if.send_out), 64'(0));
      tick(1);
      check_eq("lat_a_send",    64'(a_if.send_out), 64'(1));
      check_eq("lat_a_data",    64'(a_if.data_out), 64'h0000_0000_DEAD_BEEF);
      check_eq("lat_a_dest",    64'(a_if.dest_out), 64'h15);
      check_eq("lat_a_tail",    64'(a_if.is_tail_out), 64'(1));
      check_eq("lat_a_credit",  64'(a_if.credit_out), 64'(1));
      check_eq("lat_a_occ_0",   64'(a_if.occupancy), 64'(0));
      check_eq("lat_b_credit",  64'(b_if.credit_out), 64'(1));
      check_eq("lat_b_early",   64'(b_if.send_out), 64'(0));
      tick(1);
      check_eq("lat_a_pulse",   64'(a_if.send_out), 64'(0));
      check_eq("lat_a_cr_pulse",64'(a_if.credit_out), 64'(0));
      check_eq("lat_b_early2",  64'(b_if.send_out), 64'(0));
      tick(1);
      check_eq("lat_b_send",    64'(b_if.send_out), 64'(1));
      check_eq("lat_b_data",    64'(b_if.data_out), 64'h0000_0000_DEAD_BEEF);
      check_eq("lat_b_dest",    64'(b_if.dest_out), 64'h15);
      check_eq("lat_b_tail",    64'(b_if.is_tail_out), 64'(1));
      tick(1);
      check_eq("lat_b_pulse",   64'(b_if.send_out), 64'(0));
      a_if.credit_in = 1'b1;
      b_if.credit_in = 1'b1;
      tick(1);
      a_if.credit_in = 1'b0;
      b_if.credit_in = 1'b0;
      tick(3);

      // Credit exhaustion: four flits consume all four downstream credits.
      s0 = sent_a;
      for (int i = 0; i < 4; i++) push_a(32'h1000_0000 + i, 6'(i), (i == 3), 1'b1);
      tick(4);
      check_eq("exh_sent_4", 64'(sent_a - s0), 64'(4));
      check_eq("exh_occ_0",  64'(a_if.occupancy), 64'(0));
      s0 = sent_a;
      for (int i = 0; i < 2; i++) push_a(32'h2000_0000 + i, 6'(8'h20 + i), (i == 1), 1'b1);
      tick(3);
      check_eq("exh_occ_2",  64'(a_if.occupancy), 64'(2));
      check_eq("exh_stall",  64'(sent_a - s0), 64'(0));
      credit_a(1);
      check_eq("cr1_early",  64'(a_if.send_out), 64'(0));
      tick(1);
      check_eq("cr1_send",   64'(a_if.send_out), 64'(1));
      check_eq("cr1_occ_1",  64'(a_if.occupancy), 64'(1));
      tick(3);
      check_eq("cr1_once",   64'(sent_a - s0), 64'(1));

      // Overflow: fill to four with no credit, then one more arrives and is dropped.
      for (int i = 0; i < 3; i++) push_a(32'h3000_0000 + i, 6'(8'h30 + i), 1'b0, 1'b1);
      check_eq("ovf_occ_full", 64'(a_if.occupancy), 64'(4));
      check_eq("ovf_err_pre",  64'(a_if.overflow_err), 64'(0));
      push_a(32'hDEAD_0005, 6'h3F, 1'b1, 1'b0);
      check_eq("ovf_err_set",  64'(a_if.overflow_err), 64'(1));
      check_eq("ovf_occ_hold", 64'(a_if.occupancy), 64'(4));
      s0 = sent_a;
      credit_a(4);
      tick(4);
      check_eq("drain_sent_4", 64'(sent_a - s0), 64'(4));
      check_eq("drain_occ_0",  64'(a_if.occupancy), 64'(0));

      // Credit error: counter back at four, then one extra credit.
      credit_a(4);
      tick(1);
      check_eq("cerr_pre",     64'(a_if.credit_err), 64'(0));
      credit_a(1);
      check_eq("cerr_set",     64'(a_if.credit_err), 64'(1));
      s0 = sent_a;
      for (int i = 0; i < 5; i++) push_a(32'h4000_0000 + i, 6'(8'h08 + i), 1'b0, (i < 4));
      tick(3);
      check_eq("cerr_sat_sent", 64'(sent_a - s0), 64'(4));
      check_eq("cerr_sat_occ",  64'(a_if.occupancy), 64'(1));
      check_eq("ovf_sticky",    64'(a_if.overflow_err), 64'(1));
      check_eq("cerr_sticky",   64'(a_if.credit_err), 64'(1));

      // Mid-operation reset discards the stranded flit and clears sticky errors.
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      check_eq("rst2_occ",      64'(a_if.occupancy), 64'(0));
      check_eq("rst2_ovf_err",  64'(a_if.overflow_err), 64'(0));
      check_eq("rst2_cred_err", 64'(a_if.credit_err), 64'(0));
      check_eq("rst2_send_out", 64'(a_if.send_out), 64'(0));

      // Streaming: a flit every other cycle, each credit returned three cycles after receipt.
      s0     = sent_a;
      n_sent = 0;
      ret_sh = '0;
      for (int k = 0; k < 200; k++) begin
         ret_sh         = {ret_sh[2:0], a_if.send_out};
         a_if.credit_in = ret_sh[3];
         if ((k % 2 == 0) && (n_sent < 64)) begin
            a_if.send_in    = 1'b1;
            a_if.data_in    = $urandom();
            a_if.dest_in    = 6'($urandom_range(0, 63));
            a_if.is_tail_in = 1'($urandom_range(0, 1));
            exp_q.push_back({a_if.data_in, a_if.dest_in, a_if.is_tail_in});
            n_sent++;
         end else begin
            a_if.send_in = 1'b0;
         end
         tick(1);
      end
      a_if.send_in   = 1'b0;
      a_if.credit_in = 1'b0;
      tick(2);
      check_eq("stream_sent",    64'(sent_a - s0), 64'(64));
      check_eq("stream_pending", 64'(exp_q.size()), 64'(0));
      check_eq("stream_occ",     64'(a_if.occupancy), 64'(0));
      check_eq("stream_ovf",     64'(a_if.overflow_err), 64'(0));
      check_eq("stream_cerr",    64'(a_if.credit_err), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/noc_link_rebuffer.md
Name: noc_link_rebuffer

Overview:
- Sits on a router-to-router link, between one router's output port and the next router's input port.
- Toward upstream it acts as a credit-based receiver: it buffers the flits it receives and returns a credit each time it frees a slot.
- Toward downstream it acts as a credit-based sender: it holds a credit counter that mirrors the downstream router's flit buffer.
- Optional forward and credit-return pipeline registers break long inter-router wires without changing protocol semantics.

Parameters:
- FLIT_WIDTH, 32, data width of one flit.
- DEST_WIDTH, 6, destination field width (TDEST_WIDTH + TID_WIDTH).
- BUFFER_DEPTH, 4, local FIFO depth; upstream sender must be initialised with this many credits. Minimum 2.
- DOWNSTREAM_CREDITS, 4, reset value of the downstream credit counter; equals downstream FLIT_BUFFER_DEPTH.
- NUM_PIPELINE, 0, extra register stages on the forward output path and on the credit_in return path. Range 0..4.

Ports:
- clk_noc  in  1  NoC clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  FLIT_WIDTH  upstream flit payload.
- dest_in  in  DEST_WIDTH  upstream flit destination.
- is_tail_in  in  1  upstream flit is last of its packet.
- send_in  in  1  upstream flit valid, one flit per cycle.
- credit_out  out  1  one-cycle pulse: one local FIFO slot freed.
- data_out  out  FLIT_WIDTH  downstream flit payload.
- dest_out  out  DEST_WIDTH  downstream flit destination.
- is_tail_out  out  1  downstream tail marker.
- send_out  out  1  downstream flit valid.
- credit_in  in  1  one-cycle pulse from downstream: one slot freed.
- occupancy  out  $clog2(BUFFER_DEPTH+1)  current FIFO fill level.
- overflow_err  out  1  sticky; a flit arrived with no free slot.
- credit_err  out  1  sticky; credit returned beyond DOWNSTREAM_CREDITS.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO empty, occupancy=0.
  - credit counter = DOWNSTREAM_CREDITS.
  - All pipeline valid bits cleared.
  - send_out, credit_out, overflow_err, credit_err = 0.
  - data_out, dest_out, is_tail_out = 0.
- Reset mid-operation: buffered and in-flight flits and credits are discarded. Both neighbours must be reset in the same cycle.
- Push:
  - send_in=1 writes {data_in, dest_in, is_tail_in} at the edge.
  - Accepted when occupancy < BUFFER_DEPTH, or when occupancy == BUFFER_DEPTH and a pop occurs in the same cycle.
  - Otherwise the flit is dropped, overflow_err is set, and occupancy is unchanged.
- Pop:
  - Occurs in cycle c when occupancy > 0 and the registered credit counter > 0.
  - No same-cycle bypass of credit_in (after delay) into the pop decision.
- Timing:
  - Popped flit appears on send_out/data_out at c+1+NUM_PIPELINE, as a one-cycle pulse.
  - credit_out pulses at c+1, always registered, never pipelined.
  - credit_in pulse at cycle t increments the counter at the edge ending t+NUM_PIPELINE.
- Minimum latency: send_in at t into an empty FIFO with credit available gives pop at t+1 and send_out at t+2+NUM_PIPELINE.
- Credit counter:
  - Next value = count − pop + credit_delayed; simultaneous pop and credit leave it unchanged.
  - If the increment would exceed DOWNSTREAM_CREDITS, the counter saturates and credit_err is set.
- FIFO:
  - Circular, read/write pointers wrap at BUFFER_DEPTH, strict in-order delivery.
  - Simultaneous push and pop keep occupancy constant.
- Throughput: one flit per cycle sustained when downstream returns credits fast enough. Each pipeline stage forwards its contents every cycle, with no stalls.
- Sticky errors clear only on rst.
- Flit order, including is_tail, is preserved end to end. The block does no packet-level arbitration.

Test Plan:
- Reset: assert rst 2 cycles with send_in=1 → send_out=0, credit_out=0, occupancy=0, both errors 0. First pop after release follows only post-reset pushes.
- Latency, NUM_PIPELINE=0 then 2: single flit data=0xDEADBEEF, dest=0x15, tail=1 at cycle 10 → send_out with identical fields at cycle 12 (resp. 14). credit_out at cycle 12.
- Credit exhaustion, DOWNSTREAM_CREDITS=4, BUFFER_DEPTH=4, no credit_in: push 4 flits back-to-back → exactly 4 send_out, occupancy returns to 0. Push 2 more → occupancy=2, no send_out. Pulse credit_in once (NUM_PIPELINE=0) → exactly one send_out two cycles later, occupancy=1.
- Overflow: with zero downstream credits, push 5 flits → 5th dropped, overflow_err=1, occupancy=4. Later drain delivers the first 4 flits in order.
- Credit error: with counter at 4, pulse credit_in → credit_err=1, counter stays 4.
- Streaming: 64 random flits, downstream returns each credit 3 cycles after receipt → output order and fields match input exactly. send_in never meets a full FIFO, no errors.
